// File: rtl/sseg_sched.sv
// Seven-segment display scheduler: round-robin time-slicing of one display
// among NREQ requesters, with change-driven reloads and a blanking load when idle.
//
// state | meaning
// IDLE  | no owner; waiting for any request
// LOAD  | one cycle; latch owner's value into din/dp and strobe ld
// SHOW  | owner holds the display for DWELL ticks or until it drops req
// BLANK | one cycle; load a blank value and strobe ld
module sseg_sched #(
    parameter int         NREQ    = 4,
    parameter int         DWELL   = 250,
    parameter logic [3:0] IDLE_DP = 4'b1111
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tick,
    input  logic [NREQ-1:0]          req,
    input  logic [16*NREQ-1:0]       data,
    input  logic [4*NREQ-1:0]        dpin,
    output logic [15:0]              din,
    output logic [3:0]               dp,
    output logic                     ld,
    output logic [NREQ-1:0]          gnt,
    output logic [$clog2(NREQ)-1:0]  owner,
    output logic                     busy
);

    localparam int OW = $clog2(NREQ);
    localparam int CW = $clog2(DWELL + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHOW, BLANK} state_t;

    state_t          state, state_n;
    logic [OW-1:0]   rr, rr_n, owner_n, rr_next, arb_start, win;
    logic [CW-1:0]   cnt, cnt_n;
    logic [15:0]     din_n, own_data;
    logic [3:0]      dp_n, own_dp;
    logic            ld_n, busy_n, any_req, slot_end;

    // First asserted request at or after 'start', wrapping modulo NREQ.
    function automatic logic [OW-1:0] arb(input logic [OW-1:0] start,
                                          input logic [NREQ-1:0] r);
        logic [OW-1:0] w;
        logic          found;
        int            idx;
        w     = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(start) + i) % NREQ;
            if (!found && r[idx]) begin
                w     = OW'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign own_data  = data[int'(owner)*16 +: 16];
    assign own_dp    = dpin[int'(owner)*4 +: 4];
    assign any_req   = |req;
    assign rr_next   = OW'((int'(owner) + 1) % NREQ);
    assign arb_start = (state == IDLE) ? rr : rr_next;
    assign win       = arb(arb_start, req);
    assign slot_end  = (tick && (cnt == CW'(DWELL - 1))) || !req[owner];
    assign gnt       = busy ? (NREQ'(1) << owner) : '0;

    always_comb begin
        state_n = state;
        rr_n    = rr;
        cnt_n   = cnt;
        din_n   = din;
        dp_n    = dp;
        ld_n    = 1'b0;
        owner_n = owner;
        busy_n  = busy;
        case (state)
            IDLE: begin
                if (any_req) begin
                    owner_n = win;
                    busy_n  = 1'b1;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                din_n   = own_data;
                dp_n    = own_dp;
                ld_n    = 1'b1;
                cnt_n   = '0;
                state_n = SHOW;
            end
            SHOW: begin
                if (slot_end) begin
                    rr_n = rr_next;
                    if (any_req) begin
                        owner_n = win;
                        state_n = LOAD;
                    end else begin
                        owner_n = '0;
                        busy_n  = 1'b0;
                        state_n = BLANK;
                    end
                end else begin
                    // cnt never exceeds DWELL-1 here, so +1 cannot wrap
                    if (tick) cnt_n = cnt + CW'(1);
                    if ((own_data != din) || (own_dp != dp)) begin
                        din_n = own_data;
                        dp_n  = own_dp;
                        ld_n  = 1'b1;
                    end
                end
            end
            BLANK: begin
                din_n   = 16'h0000;
                dp_n    = IDLE_DP;
                ld_n    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            rr    <= '0;
            cnt   <= '0;
            din   <= '0;
            dp    <= '0;
            ld    <= 1'b0;
            owner <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            rr    <= rr_n;
            cnt   <= cnt_n;
            din   <= din_n;
            dp    <= dp_n;
            ld    <= ld_n;
            owner <= owner_n;
            busy  <= busy_n;
        end
    end

endmodule

// File: tb/tb_sseg_sched.sv
// Self-checking bench for sseg_sched: directed scenarios plus randomized traffic
// compared cycle by cycle against a slot-level behavioural model.
module tb_sseg_sched;

    localparam int         NREQ  = 4;
    localparam int         DWELL = 3;
    localparam logic [3:0] IDP   = 4'b1010;

    logic               clk = 1'b0;
    logic               reset;
    logic               tick;
    logic [NREQ-1:0]    req;
    logic [16*NREQ-1:0] data;
    logic [4*NREQ-1:0]  dpin;
    logic [15:0]        din;
    logic [3:0]         dp;
    logic               ld;
    logic [NREQ-1:0]    gnt;
    logic [1:0]         owner;
    logic               busy;

    sseg_sched #(.NREQ(NREQ), .DWELL(DWELL), .IDLE_DP(IDP)) dut (
        .clk(clk), .reset(reset), .tick(tick), .req(req), .data(data), .dpin(dpin),
        .din(din), .dp(dp), .ld(ld), .gnt(gnt), .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: who holds the display, how many ticks of the slot have elapsed,
    // and which one-cycle action (load or blank) is due at the next edge.
    int         m_owner, m_rr, m_ticks;
    bit         m_busy, m_load_due, m_blank_due, m_ld;
    logic [15:0] m_din;
    logic [3:0]  m_dp;

    function automatic int first_req(input int start, input logic [NREQ-1:0] r);
        for (int i = 0; i < NREQ; i++)
            if (r[(start + i) % NREQ]) return (start + i) % NREQ;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = 0; m_rr = 0; m_ticks = 0; m_busy = 0;
        m_load_due = 0; m_blank_due = 0; m_ld = 0; m_din = '0; m_dp = '0;
    endtask

    task automatic model_step();
        logic [15:0] v;
        logic [3:0]  p;
        int          w;
        v = data[16*m_owner +: 16];
        p = dpin[4*m_owner +: 4];
        m_ld = 0;
        if (m_blank_due) begin
            m_din = 16'h0000; m_dp = IDP; m_ld = 1; m_blank_due = 0;
        end else if (m_load_due) begin
            m_din = v; m_dp = p; m_ld = 1; m_ticks = 0; m_load_due = 0;
        end else if (m_busy) begin
            if ((tick && m_ticks == DWELL - 1) || !req[m_owner]) begin
                m_rr = (m_owner + 1) % NREQ;
                w = first_req(m_rr, req);
                if (w >= 0) begin
                    m_owner = w; m_load_due = 1;
                end else begin
                    m_owner = 0; m_busy = 0; m_blank_due = 1;
                end
            end else begin
                if (tick) m_ticks++;
                if (v != m_din || p != m_dp) begin
                    m_din = v; m_dp = p; m_ld = 1;
                end
            end
        end else begin
            w = first_req(m_rr, req);
            if (w >= 0) begin
                m_owner = w; m_busy = 1; m_load_due = 1;
            end
        end
    endtask

    task automatic cmp_all();
        chk("din", 32'(din), 32'(m_din));
        chk("dp", 32'(dp), 32'(m_dp));
        chk("ld", 32'(ld), 32'(m_ld));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("owner", 32'(owner), 32'(m_owner));
        chk("gnt", 32'(gnt), m_busy ? (32'd1 << m_owner) : 32'd0);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cmp_all();
    endtask

    task automatic async_reset(input logic [NREQ-1:0] req_after);
        @(posedge clk);
        model_step();
        #2 reset = 1'b0;
        #1 model_reset();
        cmp_all();
        chk("rst_async_gnt", 32'(gnt), 32'd0);
        @(negedge clk);
        req   = req_after;
        reset = 1'b1;
    endtask

    logic [15:0] vals [4] = '{16'h1234, 16'hAAAA, 16'h5555, 16'h0F0F};

    initial begin
        reset = 1'b0; tick = 1'b0; req = '0; data = '0; dpin = '0;
        model_reset();
        #12;
        cmp_all();
        chk("rst_dp", 32'(dp), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // single requester, back-to-back slots with no grant gap
        data[15:0] = 16'h1234; dpin[3:0] = 4'h0; req = 4'b0001;
        cycle();
        chk("single_gnt", 32'(gnt), 32'h1);
        cycle();
        chk("single_ld", 32'(ld), 32'd1);
        chk("single_din", 32'(din), 32'h1234);
        tick = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("single_nogap", 32'(gnt), 32'h1);
        end
        tick = 1'b0;

        // owner drops with nobody else waiting: blank load then idle
        req = 4'b0000;
        repeat (4) cycle();
        chk("blank_busy", 32'(busy), 32'd0);
        chk("blank_din", 32'(din), 32'h0);
        chk("blank_dp", 32'(dp), 32'(IDP));

        // reset during a slot, then arbitration restarts from requester 0
        data[47:32] = 16'hAAAA; req = 4'b0100;
        repeat (4) cycle();
        async_reset(4'b0100);
        cycle();
        chk("post_rst_gnt", 32'(gnt), 32'h4);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(7) == 0) req = NREQ'($urandom);
            tick = ($urandom_range(2) == 0);
            if ($urandom_range(9) == 0) begin
                int r;
                r = $urandom_range(NREQ - 1);
                data[16*r +: 16] = vals[$urandom_range(3)];
                dpin[4*r +: 4]   = 4'($urandom);
            end
            if (n % 700 == 699) async_reset(NREQ'($urandom));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
